accu_sched: RTL and testbench

Round-robin scheduler that time-shares one saturating accumulator datapath between N_CH requesters. Each requester owns a private accumulator register held inside the block. Each cycle at most one requester is granted. Its signed increment is added to its own register with symmetric clamping at ±LIMIT. The block sits between the per-channel rate sources (angular increments) and the downstream phase consumers, replacing N separate accumulator instances.

---
 rtl/accu_sched.sv | 123 ++++++++++++
 tb/tb_accu_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accu_sched.sv
// accu_sched: round-robin shared saturating accumulator for N_CH requesters.
// Define ACCU_SCHED_WRAP_EN to wrap at +/-LIMIT instead of clamping.
module accu_sched #(
  parameter int N_CH     = 4,
  parameter int IN_WIDTH = 15,
  parameter int SIZE     = 26,
  parameter int LIMIT    = 18849555,
  parameter int CHW      = $clog2(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            req,
  input  logic [N_CH*IN_WIDTH-1:0]   in_flat,
  input  logic [N_CH-1:0]            clr,
  input  logic [CHW-1:0]             rd_ch,
  output logic [N_CH-1:0]            grant,
  output logic                       out_valid,
  output logic [CHW-1:0]             out_ch,
  output logic signed [SIZE-1:0]     out_acc,
  output logic                       out_sat,
  output logic signed [SIZE-1:0]     rd_data
);

  localparam int AW = SIZE + 2;
  localparam logic signed [AW-1:0] LIM  = AW'(LIMIT);
  localparam logic signed [AW-1:0] NLIM = -LIM;
`ifdef ACCU_SCHED_WRAP_EN
  localparam logic signed [AW-1:0] TWO_LIM = LIM + LIM;
`endif

  logic signed [SIZE-1:0]     acc [N_CH];
  logic [CHW-1:0]             rr_ptr;
  logic signed [IN_WIDTH-1:0] inc_a [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_slice
    assign inc_a[i] = in_flat[i*IN_WIDTH +: IN_WIDTH];
  end

  logic           found;
  logic [CHW-1:0] win;
  logic [CHW:0]   idx;

  // search starts at rr_ptr and wraps modulo N_CH
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = {1'b0, rr_ptr} + (CHW+1)'(k);
      if (idx >= (CHW+1)'(N_CH))
        idx = idx - (CHW+1)'(N_CH);
      if (!found && req[idx[CHW-1:0]]) begin
        found = 1'b1;
        win   = idx[CHW-1:0];
      end
    end
  end

  logic signed [AW-1:0]   ext;
  logic signed [AW-1:0]   base;
  logic signed [AW-1:0]   nxt;
  logic signed [SIZE-1:0] res;
  logic                   sat;

  always_comb begin
    ext  = AW'(inc_a[win]);
    base = clr[win] ? '0 : AW'(acc[win]);
    nxt  = base + ext;
    res  = nxt[SIZE-1:0];
    sat  = 1'b0;
`ifdef ACCU_SCHED_WRAP_EN
    // low SIZE bits of nxt -/+ 2*LIMIT are exact: the result fits SIZE
    if (nxt > LIM) begin
      res = nxt[SIZE-1:0] - TWO_LIM[SIZE-1:0];
      sat = 1'b1;
    end else if (nxt < NLIM) begin
      res = nxt[SIZE-1:0] + TWO_LIM[SIZE-1:0];
      sat = 1'b1;
    end
`else
    if (nxt > LIM) begin
      res = LIM[SIZE-1:0];
      sat = 1'b1;
    end else if (nxt < NLIM) begin
      res = NLIM[SIZE-1:0];
      sat = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++)
        acc[i] <= '0;
      rr_ptr    <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_acc   <= '0;
      out_sat   <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_data <= (int'(rd_ch) < N_CH) ? acc[rd_ch] : '0;
      for (int i = 0; i < N_CH; i++)
        if (clr[i])
          acc[i] <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      // winner write follows the clears so a cleared winner keeps sat(ext)
      if (found) begin
        acc[win]  <= res;
        grant     <= N_CH'(1) << win;
        out_valid <= 1'b1;
        out_ch    <= win;
        out_acc   <= res;
        out_sat   <= sat;
        rr_ptr    <= (int'(win) == N_CH-1) ? '0 : win + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_accu_sched.sv
// tb_accu_sched: vector table, corner sequences and random run
// against an arithmetic reference model of the scheduler.
module tb_accu_sched;

  localparam int N  = 4;
  localparam int IW = 15;
  localparam int SZ = 26;
  localparam longint L = 18849555;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*IW-1:0] in_flat;
  logic [N-1:0]  clr;
  logic [1:0]    rd_ch;
  logic [N-1:0]  grant;
  logic          out_valid;
  logic [1:0]    out_ch;
  logic signed [SZ-1:0] out_acc;
  logic          out_sat;
  logic signed [SZ-1:0] rd_data;

  accu_sched dut (
    .clk(clk), .rst(rst), .req(req), .in_flat(in_flat),
    .clr(clr), .rd_ch(rd_ch), .grant(grant),
    .out_valid(out_valid), .out_ch(out_ch), .out_acc(out_acc),
    .out_sat(out_sat), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  longint m_acc [N];
  int     m_ptr;
  longint e_grant, e_valid, e_ch, e_acc, e_sat, e_rd;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endfunction

  // model step on current inputs, clock edge, then compare
  task automatic tick();
    int w;
    int idx;
    longint nxt;
    if (rst) begin
      for (int i = 0; i < N; i++) m_acc[i] = 0;
      m_ptr = 0;
      e_grant = 0; e_valid = 0; e_ch = 0;
      e_acc = 0; e_sat = 0; e_rd = 0;
    end else begin
      e_rd = (int'(rd_ch) < N) ? m_acc[rd_ch] : 0;
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (w < 0 && req[idx]) w = idx;
      end
      for (int i = 0; i < N; i++)
        if (clr[i]) m_acc[i] = 0;
      e_grant = 0; e_valid = 0; e_sat = 0;
      if (w >= 0) begin
        nxt = m_acc[w] + longint'($signed(in_flat[w*IW +: IW]));
`ifdef ACCU_SCHED_WRAP_EN
        if (nxt > L) begin nxt = nxt - 2*L; e_sat = 1; end
        else if (nxt < -L) begin nxt = nxt + 2*L; e_sat = 1; end
`else
        if (nxt > L) begin nxt = L; e_sat = 1; end
        else if (nxt < -L) begin nxt = -L; e_sat = 1; end
`endif
        m_acc[w] = nxt;
        e_grant = longint'(1) << w;
        e_valid = 1;
        e_ch = w;
        e_acc = nxt;
        m_ptr = (w + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    chk("grant", longint'(grant), e_grant);
    chk("valid", longint'(out_valid), e_valid);
    chk("sat", longint'(out_sat), e_sat);
    chk("rd_data", longint'(rd_data), e_rd);
    if (e_valid != 0) begin
      chk("out_ch", longint'(out_ch), e_ch);
      chk("out_acc", longint'(out_acc), e_acc);
    end
  endtask

  task automatic set_inc(int ch, int v);
    in_flat[ch*IW +: IW] = IW'(v);
  endtask

  task automatic set_inc_all(int v);
    for (int i = 0; i < N; i++) set_inc(i, v);
  endtask

  task automatic acc_once(int ch, int v);
    rst = 1'b0;
    clr = '0;
    req = '0;
    req[ch] = 1'b1;
    set_inc(ch, v);
    tick();
    req = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; clr = '0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit       rst;
    logic [3:0] req;
    logic [3:0] clr;
    int       inc;
    logic [1:0] rd;
    logic [3:0] g;
    bit       v;
    int       ch;
    int       acc;
    bit       sat;
    int       rdv;
  } vec_t;

  vec_t tv [16];

  initial begin
    tv[0]  = '{1'b0, 4'b0001, 4'b0000, 100, 2'd0, 4'b0001, 1'b1, 0, 100, 1'b0, 0};
    tv[1]  = '{1'b0, 4'b0000, 4'b0000, 100, 2'd0, 4'b0000, 1'b0, 0, 100, 1'b0, 100};
    tv[2]  = '{1'b0, 4'b0001, 4'b0000, 100, 2'd0, 4'b0001, 1'b1, 0, 200, 1'b0, 100};
    tv[3]  = '{1'b0, 4'b0000, 4'b0000, 100, 2'd0, 4'b0000, 1'b0, 0, 200, 1'b0, 200};
    tv[4]  = '{1'b0, 4'b0001, 4'b0000, 100, 2'd0, 4'b0001, 1'b1, 0, 300, 1'b0, 200};
    tv[5]  = '{1'b0, 4'b0000, 4'b0000, 100, 2'd0, 4'b0000, 1'b0, 0, 300, 1'b0, 300};
    tv[6]  = '{1'b1, 4'b0000, 4'b0000, 1,   2'd0, 4'b0000, 1'b0, 0, 0,   1'b0, 0};
    tv[7]  = '{1'b0, 4'b1111, 4'b0000, 1,   2'd0, 4'b0001, 1'b1, 0, 1,   1'b0, 0};
    tv[8]  = '{1'b0, 4'b1111, 4'b0000, 1,   2'd0, 4'b0010, 1'b1, 1, 1,   1'b0, 1};
    tv[9]  = '{1'b0, 4'b1111, 4'b0000, 1,   2'd0, 4'b0100, 1'b1, 2, 1,   1'b0, 1};
    tv[10] = '{1'b0, 4'b1111, 4'b0000, 1,   2'd0, 4'b1000, 1'b1, 3, 1,   1'b0, 1};
    tv[11] = '{1'b0, 4'b1111, 4'b0000, 1,   2'd0, 4'b0001, 1'b1, 0, 2,   1'b0, 1};
    tv[12] = '{1'b0, 4'b1111, 4'b0000, 1,   2'd0, 4'b0010, 1'b1, 1, 2,   1'b0, 2};
    tv[13] = '{1'b1, 4'b1111, 4'b0000, 1,   2'd0, 4'b0000, 1'b0, 0, 0,   1'b0, 0};
    tv[14] = '{1'b0, 4'b1111, 4'b0000, 1,   2'd2, 4'b0001, 1'b1, 0, 1,   1'b0, 0};
    tv[15] = '{1'b0, 4'b0000, 4'b0000, 1,   2'd1, 4'b0000, 1'b0, 0, 1,   1'b0, 0};

    rst = 1'b1; req = '0; clr = '0; in_flat = '0; rd_ch = '0;
    tick();
    chk("reset_acc", longint'(out_acc), 0);
    chk("reset_ch", longint'(out_ch), 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      rst = tv[i].rst; req = tv[i].req; clr = tv[i].clr;
      rd_ch = tv[i].rd;
      set_inc_all(tv[i].inc);
      tick();
      chk($sformatf("tv%0d_grant", i), longint'(grant), longint'(tv[i].g));
      chk($sformatf("tv%0d_valid", i), longint'(out_valid), longint'(tv[i].v));
      chk($sformatf("tv%0d_ch", i), longint'(out_ch), longint'(tv[i].ch));
      chk($sformatf("tv%0d_acc", i), longint'(out_acc), longint'(tv[i].acc));
      chk($sformatf("tv%0d_sat", i), longint'(out_sat), longint'(tv[i].sat));
      chk($sformatf("tv%0d_rd", i), longint'(rd_data), longint'(tv[i].rdv));
    end
    rst = 1'b0; req = '0;

    // clear together with accumulate, and clear without request
    do_reset();
    acc_once(0, 500);
    acc_once(2, 50);
    req = 4'b0001; clr = 4'b0101; rd_ch = 2'd0;
    set_inc(0, -7);
    tick();
    chk("clrw_acc", longint'(out_acc), -7);
    chk("clrw_grant", longint'(grant), 1);
    chk("clrw_rd", longint'(rd_data), 500);
    req = '0; clr = '0; rd_ch = 2'd2;
    tick();
    chk("clr2_rd", longint'(rd_data), 0);
    rd_ch = 2'd0;
    tick();
    chk("clr0_rd", longint'(rd_data), -7);

`ifndef ACCU_SCHED_WRAP_EN
    do_reset();
    for (int i = 0; i < 1150; i++) acc_once(1, 16383);
    acc_once(1, 8550);
    chk("pre_acc", longint'(out_acc), 18849000);
    acc_once(1, 16383);
    chk("satp_acc", longint'(out_acc), L);
    chk("satp_flag", longint'(out_sat), 1);
    chk("satp_ch", longint'(out_ch), 1);
    acc_once(1, -16384);
    chk("back_acc", longint'(out_acc), 18833171);
    chk("back_flag", longint'(out_sat), 0);
    req = '0; clr = 4'b0010;
    tick();
    clr = '0;
    for (int i = 0; i < 1151; i++) acc_once(1, -16384);
    chk("satn_acc", longint'(out_acc), -L);
    chk("satn_flag", longint'(out_sat), 1);
`else
    do_reset();
    for (int i = 0; i < 1150; i++) acc_once(0, 16383);
    acc_once(0, 9050);
    acc_once(0, 100);
    chk("wrap_acc", longint'(out_acc), -18849510);
    chk("wrap_flag", longint'(out_sat), 1);
`endif

    // random traffic, occasional clears and resets
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      req = 4'($urandom);
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      rd_ch = 2'($urandom);
      for (int i = 0; i < N; i++)
        set_inc(i, int'($urandom_range(0, 32767)) - 16384);
      tick();
    end

    // biased drive so every channel reaches the limits
    rst = 1'b0; clr = '0;
    for (int n = 0; n < 5200; n++) begin
      req = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b1111;
      rd_ch = 2'($urandom);
      for (int i = 0; i < N; i++)
        set_inc(i, int'($urandom_range(8000, 16383)));
      tick();
    end
    for (int n = 0; n < 600; n++) begin
      req = 4'($urandom);
      rd_ch = 2'($urandom);
      for (int i = 0; i < N; i++)
        set_inc(i, -int'($urandom_range(0, 16384)));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
